sm_initiator: RTL and testbench

Initiator end of the single-wire request/acknowledge handshake used by the microfluidics valve/pump sequencer state machines. Accepts one command at a time over a valid/ready interface and drives the responder's `sm_in` line through the full idle→write→wait→idle cycle. It senses the responder's `sm_out` line, reports completion or timeout, and counts completed transactions. It sits between the controller's command path and each responder sequencer.

---
 rtl/sm_proto_pkg.sv | 25 ++
 rtl/sm_timeout_ctr.sv | 30 +++
 rtl/sm_initiator.sv | 107 ++++++++++
 tb/tb_sm_initiator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_proto_pkg.sv
// Shared definitions for the sm_in/sm_out single-wire handshake, used by the
// initiator and the responder sequencers.
package sm_proto_pkg;

   typedef logic [2:0] sm_state_t;

   localparam sm_state_t ST_IDLE    = 3'd0;
   localparam sm_state_t ST_ARM     = 3'd1;
   localparam sm_state_t ST_RELEASE = 3'd2;
   localparam sm_state_t ST_ACK     = 3'd3;
   localparam sm_state_t ST_CHECK   = 3'd4;
   localparam sm_state_t ST_DONE    = 3'd5;
   localparam sm_state_t ST_ERROR   = 3'd6;

   // Responder line levels: low while idle or writing, high while waiting.
   localparam logic SENSE_IDLE = 1'b0;
   localparam logic SENSE_WAIT = 1'b1;

   localparam int unsigned TIMEOUT_DEFAULT = 64;

   function automatic logic is_wait_state(input sm_state_t s);
      return (s == ST_RELEASE) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/sm_timeout_ctr.sv
// Clear/enable cycle counter flagging when LIMIT cycles have been spent waiting.
module sm_timeout_ctr
   import sm_proto_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] r_count;

   // Saturates at LAST so a stalled waiter never wraps back below the limit.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_expired = (r_count == LAST);

endmodule

// File: rtl/sm_initiator.sv
// Initiator side of the sm_in/sm_out handshake: accepts one command, drives the
// write/ack sequence on sm_drive, and reports completion, timeout and a txn count.
module sm_initiator
   import sm_proto_pkg::*;
#(
   parameter int unsigned HOLD_W  = 8,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              i_sm_clock,
   input  logic              i_reset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [HOLD_W-1:0] i_cmd_hold,
   output logic              o_sm_drive,
   input  logic              i_sm_sense,
   output logic              o_done,
   output logic              o_error,
   input  logic              i_err_clear,
   output logic [CNT_W-1:0]  o_txn_count
);

   sm_state_t         r_state;
   sm_state_t         w_state_d;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] r_arm_cnt;
   logic              r_drive;
   logic              r_done;
   logic              r_error;
   logic [CNT_W-1:0]  r_txn_count;
   logic              w_accept;
   logic              w_arm_last;
   logic              w_expired;
   logic              w_tmo_clear;
   logic              w_tmo_enable;

   assign o_cmd_ready = (r_state == ST_IDLE) && (i_sm_sense == SENSE_IDLE);
   assign w_accept    = i_cmd_valid && o_cmd_ready;
   assign w_arm_last  = (r_arm_cnt == (r_hold - HOLD_W'(1)));

   // The expected level takes priority over an expiring timeout in the same cycle.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_state_d = ST_ARM;
         ST_ARM:     if (w_arm_last) w_state_d = ST_RELEASE;
         ST_RELEASE: begin
            if (i_sm_sense == SENSE_WAIT) w_state_d = ST_ACK;
            else if (w_expired)           w_state_d = ST_ERROR;
         end
         ST_ACK:     w_state_d = ST_CHECK;
         ST_CHECK:   begin
            if (i_sm_sense == SENSE_IDLE) w_state_d = ST_DONE;
            else if (w_expired)           w_state_d = ST_ERROR;
         end
         ST_DONE:    w_state_d = ST_IDLE;
         ST_ERROR:   if (i_err_clear) w_state_d = ST_IDLE;
         default:    w_state_d = ST_IDLE;
      endcase
   end

   assign w_tmo_enable = is_wait_state(r_state);
   assign w_tmo_clear  = is_wait_state(w_state_d) && (w_state_d != r_state);

   sm_timeout_ctr #(
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .i_clk     (i_sm_clock),
      .i_reset   (i_reset),
      .i_clear   (w_tmo_clear),
      .i_enable  (w_tmo_enable),
      .o_expired (w_expired)
   );

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge i_sm_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_hold      <= '0;
         r_arm_cnt   <= '0;
         r_drive     <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_txn_count <= '0;
      end else begin
         r_state <= w_state_d;
         r_drive <= (w_state_d == ST_ARM) || (w_state_d == ST_ACK);
         r_done  <= (w_state_d == ST_DONE);
         r_error <= (w_state_d == ST_ERROR);
         if (w_state_d == ST_DONE) begin
            r_txn_count <= r_txn_count + CNT_W'(1);
         end
         if (w_accept) begin
            r_hold    <= (i_cmd_hold == '0) ? HOLD_W'(1) : i_cmd_hold;
            r_arm_cnt <= '0;
         end else if (r_state == ST_ARM) begin
            r_arm_cnt <= r_arm_cnt + HOLD_W'(1);
         end
      end
   end

   assign o_sm_drive  = r_drive;
   assign o_done      = r_done;
   assign o_error     = r_error;
   assign o_txn_count = r_txn_count;

endmodule

// File: tb/tb_sm_initiator.sv
// Directed bench for sm_initiator against an ideal registered responder model.
module tb_sm_initiator;

   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned TIMEOUT = 64;
   localparam int unsigned CNT_W   = 4;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_WRITE = 2'd1;
   localparam logic [1:0] R_WAIT  = 2'd2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              valid = 1'b0;
   logic              err_clear = 1'b0;
   logic [HOLD_W-1:0] hold = '0;
   logic              ready;
   logic              drive;
   logic              sense;
   logic              done;
   logic              error;
   logic [CNT_W-1:0]  cnt;

   int errors = 0;
   int checks = 0;
   int sense_mode = 0;  // 0: responder model, 1: stuck low, 2: stuck high
   int n_wr;
   int n_acc;
   int waited;
   int n_hi;
   logic [1:0]  r_resp;
   logic [31:0] tr_drive;
   logic [31:0] tr_done;
   logic [31:0] tr_ready;

   always #5 clk = ~clk;

   sm_initiator #(
      .HOLD_W  (HOLD_W),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .i_sm_clock  (clk),
      .i_reset     (rst),
      .i_cmd_valid (valid),
      .o_cmd_ready (ready),
      .i_cmd_hold  (hold),
      .o_sm_drive  (drive),
      .i_sm_sense  (sense),
      .o_done      (done),
      .o_error     (error),
      .i_err_clear (err_clear),
      .o_txn_count (cnt)
   );

   assign sense = (sense_mode == 0) ? (r_resp == R_WAIT) : (sense_mode == 2);

   always @(posedge clk) begin
      if (rst) begin
         r_resp <= R_IDLE;
         n_wr   <= 0;
      end else begin
         case (r_resp)
            R_IDLE:  if (drive) begin r_resp <= R_WRITE; n_wr <= n_wr + 1; end
            R_WRITE: if (!drive) r_resp <= R_WAIT;
            R_WAIT:  if (drive) r_resp <= R_IDLE;
            default: r_resp <= R_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst) n_acc <= 0;
      else if (valid && ready) n_acc <= n_acc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1 with ready high; the following edge is the accept edge.
   task automatic accept(input logic [HOLD_W-1:0] h);
      hold  = h;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
      hold  = 8'hAA;
   endtask

   // Records cycles 1..n after the accept edge (bit k = cycle k).
   task automatic capture(input int n);
      tr_drive = '0;
      tr_done  = '0;
      tr_ready = '0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         tr_drive[k] = drive;
         tr_done[k]  = done;
         tr_ready[k] = ready;
      end
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (done) begin
            n = k;
            break;
         end
      end
      if (n == 0) check_eq("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_drive", drive, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_error", error, 0);
      check_eq("rst_count", cnt, 0);
      check_eq("rst_ready", ready, 1);

      // Reset during the second ARM cycle.
      @(posedge clk); #1;
      accept(8'd5);
      @(negedge clk);
      check_eq("arm_c1_drive", drive, 1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_drive", drive, 0);
      check_eq("midrst_ready", ready, 1);
      check_eq("midrst_count", cnt, 0);
      capture(8);
      check_eq("midrst_nodone", tr_done, 0);
      check_eq("midrst_nodrive", tr_drive, 0);

      // H=3 with the ideal responder.
      @(posedge clk); #1;
      accept(8'd3);
      capture(10);
      check_eq("h3_drive", tr_drive, 32'h0000_004E);
      check_eq("h3_done", tr_done, 32'h0000_0100);
      check_eq("h3_ready", tr_ready, 32'h0000_0600);
      check_eq("h3_count", cnt, 1);
      check_eq("h3_resp_idle", r_resp, R_IDLE);

      // Hold of 0 behaves as H=1.
      @(posedge clk); #1;
      accept(8'd0);
      capture(8);
      check_eq("h0_drive", tr_drive, 32'h0000_0012);
      check_eq("h0_done", tr_done, 32'h0000_0040);
      check_eq("h0_ready", tr_ready, 32'h0000_0180);
      check_eq("h0_count", cnt, 2);

      // Sense high in IDLE blocks acceptance.
      @(posedge clk); #1;
      sense_mode = 2;
      hold  = 8'd2;
      valid = 1'b1;
      @(negedge clk);
      check_eq("busy_ready", ready, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("busy_nodrive", drive, 0);
      @(posedge clk); #1;
      sense_mode = 0;
      @(posedge clk); #1;
      valid = 1'b0;
      @(negedge clk);
      check_eq("busy_accept_drive", drive, 1);
      wait_done(20, waited);
      check_eq("busy_count", cnt, 3);

      // Responder never answers: timeout after 64 RELEASE cycles.
      @(posedge clk); #1;
      sense_mode = 1;
      accept(8'd1);
      n_hi = 0;
      for (int k = 1; k <= 66; k++) begin
         @(negedge clk);
         n_hi += int'(drive);
         if (k == 65) check_eq("tmo_c65_error", error, 0);
         if (k == 66) begin
            check_eq("tmo_c66_error", error, 1);
            check_eq("tmo_c66_drive", drive, 0);
            check_eq("tmo_c66_ready", ready, 0);
         end
      end
      check_eq("tmo_drive_cycles", n_hi, 1);
      @(posedge clk); #1;
      valid = 1'b1;
      repeat (4) @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      check_eq("err_sticky", error, 1);
      check_eq("err_drive", drive, 0);
      @(posedge clk); #1 err_clear = 1'b1;
      @(negedge clk);
      check_eq("clr_pending_error", error, 1);
      @(posedge clk); #1 err_clear = 1'b0;
      @(negedge clk);
      check_eq("clr_ready", ready, 1);
      check_eq("clr_error", error, 0);
      check_eq("clr_count", cnt, 3);

      // 17 back-to-back transactions with a 4-bit counter.
      @(posedge clk); #1;
      rst = 1'b1;
      sense_mode = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("wrap_start_count", cnt, 0);
      @(posedge clk); #1;
      hold  = 8'd2;
      valid = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         wait_done(30, waited);
         if (i == 2)  check_eq("b2b_spacing", waited, 8);
         if (i >= 15) check_eq($sformatf("wrap_count_%0d", i), cnt, i % 16);
      end
      @(posedge clk); #1 valid = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("wrap_writes", n_wr, 17);
      check_eq("wrap_accepts", n_acc, 17);
      check_eq("wrap_resp_idle", r_resp, R_IDLE);
      check_eq("wrap_final_count", cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
